xadc_channel_reader: RTL and testbench
======================================

XADC_CHANNEL_READER -- requirements
Module: xadc_channel_reader

Interface
REQ-001 Parameter FILT_SHIFT, default 2, IIR smoothing shift; 0 = no filtering.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles to wait for drdy after a DRP request.
REQ-003 CLK100MHZ  in  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 eoc  in  1  end-of-conversion pulse from xadc_wiz_0.
REQ-006 channel  in  5  channel_out from xadc_wiz_0, valid with eoc.
REQ-007 drdy  in  1  DRP data-ready from xadc_wiz_0.
REQ-008 do_in  in  16  DRP read data; result in [15:4].
REQ-009 den  out  1  DRP enable, one-cycle pulse.
REQ-010 daddr  out  7  DRP address.
REQ-011 dwe  out  1  DRP write enable, constant 0.
REQ-012 ch6_val, ch7_val, ch14_val, ch15_val  out  12 each  filtered result per aux channel.
REQ-013 sample_valid  out  1  one-cycle pulse when a channel value updates.
REQ-014 sample_ch  out  2  index of the updated channel: 0=aux6, 1=aux7, 2=aux14, 3=aux15.
REQ-015 timeout_err  out  1  sticky flag: a DRP read never completed.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, STORE.
REQ-017 IDLE->REQ: eoc=1 and channel is 0x16, 0x17, 0x1E or 0x1F.
  - Latch daddr = {2'b00, channel}.
  - Latch the 2-bit channel index.
REQ-018 In IDLE, eoc on any other channel is ignored.
REQ-019 REQ lasts exactly one cycle.
  - den=1 and daddr is held.
  - Next state is WAIT.
REQ-020 den is 0 in every state except REQ.
REQ-021 WAIT->STORE on drdy=1.
  - Capture do_in[15:4] as the raw sample.
REQ-022 WAIT->IDLE when the wait counter reaches TIMEOUT without drdy.
  - Set timeout_err; the channel value is not changed.
REQ-023 Wait counter: 8 bits or wider; clears on entering WAIT; increments once per WAIT cycle.
REQ-024 eoc asserted in REQ, WAIT or STORE is ignored.
  - No queuing and no error.
REQ-025 drdy asserted in IDLE, REQ or STORE is ignored.
REQ-026 STORE lasts one cycle and updates the selected channel value. Let v = current value, r = raw sample.
  - Channel not primed: v <= r, and the channel is marked primed.
  - Channel primed: v <= v + ((r - v) >>> FILT_SHIFT).
  - Compute the difference signed at 13 bits; the result never exceeds 0..4095.
  - FILT_SHIFT = 0: v <= r.
REQ-027 The cycle after STORE:
  - sample_valid=1 and sample_ch = the updated index for exactly one cycle.
  - The new chN_val is visible in the same cycle.
  - The FSM is back in IDLE.
REQ-028 Latency: eoc in cycle 0 -> den in cycle 1 -> drdy in cycle k -> sample_valid in cycle k+2.
REQ-029 eoc can be accepted again in the same cycle that sample_valid is high.
REQ-030 Values of the non-selected channels never change.

Reset
REQ-031 rst_n=0 forces, asynchronously:
  - state IDLE; den=0, daddr=0, dwe=0;
  - all chN_val=0; sample_valid=0, sample_ch=0, timeout_err=0;
  - all primed flags cleared; wait counter 0.
REQ-032 Reset during REQ or WAIT abandons the transaction.
  - A drdy arriving after release of rst_n, while in IDLE, is ignored.
REQ-033 timeout_err clears only on reset.

Verification
REQ-034 After reset: eoc with channel=0x1E, drdy 3 cycles after den, do_in=16'hA5C0.
  - Required: den pulses once with daddr=0x1E.
  - Required: ch14_val=12'hA5C, sample_valid pulse with sample_ch=2.
REQ-035 Filtering, FILT_SHIFT=2, aux6 primed at 0x400, new sample 0x800.
  - Required: ch6_val=0x500.
  - Next sample 0x000: ch6_val=0x3C0.
REQ-036 Non-aux and busy eoc:
  - eoc with channel=0x03: no den pulse.
  - eoc during WAIT: no second den pulse; exactly one sample_valid results.
REQ-037 Timeout, TIMEOUT=8, drdy never asserted:
  - timeout_err=1 and FSM in IDLE after 8 WAIT cycles.
  - Channel value unchanged; no sample_valid.
  - A later normal read still succeeds.
REQ-038 Reset mid-WAIT, then late drdy:
  - All outputs return to reset values.
  - The late drdy causes no update.
  - The next aux7 read with do_in=16'hFFF0 gives ch7_val=12'hFFF (unprimed load).

Source files
------------

// File: rtl/xadc_channel_reader.sv
// Reads the four XADC aux channels (6, 7, 14, 15) over DRP after each end-of-conversion
// and keeps an IIR-smoothed 12-bit value per channel.
module xadc_channel_reader #(
    parameter int FILT_SHIFT = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        CLK100MHZ,
    input  logic        rst_n,
    input  logic        eoc,
    input  logic [4:0]  channel,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic        den,
    output logic [6:0]  daddr,
    output logic        dwe,
    output logic [11:0] ch6_val,
    output logic [11:0] ch7_val,
    output logic [11:0] ch14_val,
    output logic [11:0] ch15_val,
    output logic        sample_valid,
    output logic [1:0]  sample_ch,
    output logic        timeout_err,
    output logic [1:0]  state_dbg
);

    // Handshake: den is a single-cycle DRP request; drdy is honoured only in WAIT,
    // and sample_valid pulses once per completed read with the value already updated.

    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_STORE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    ch_idx;
    logic [11:0]   raw;
    logic [11:0]   ch_val [4];
    logic [3:0]    primed;
    logic          is_aux;
    logic          wait_expired;
    logic [11:0]   cur_val;
    logic signed [12:0] diff;
    logic signed [12:0] step;
    logic [11:0]   filt_val;
    logic          unused_ok;

    assign is_aux = (channel == 5'h16) || (channel == 5'h17) ||
                    (channel == 5'h1E) || (channel == 5'h1F);
    assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));
    assign unused_ok = &{1'b0, do_in[3:0]};

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (eoc && is_aux) state_nxt = S_REQ;
            S_REQ:   state_nxt = S_WAIT;
            S_WAIT:  if (drdy) state_nxt = S_STORE;
                     else if (wait_expired) state_nxt = S_IDLE;
            S_STORE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        den       = (state == S_REQ);
        dwe       = 1'b0;
        state_dbg = state;
    end

    // Difference is taken signed at 13 bits; an arithmetic shift keeps the result between v and r.
    always_comb begin
        cur_val  = ch_val[ch_idx];
        diff     = $signed({1'b0, raw}) - $signed({1'b0, cur_val});
        step     = diff >>> FILT_SHIFT;
        filt_val = raw;
        if (primed[ch_idx] && FILT_SHIFT != 0)
            filt_val = 12'($signed({1'b0, cur_val}) + step);
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            daddr        <= '0;
            ch_idx       <= '0;
            wait_cnt     <= '0;
            raw          <= '0;
            primed       <= '0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            timeout_err  <= 1'b0;
            for (int i = 0; i < 4; i++) ch_val[i] <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (eoc && is_aux) begin
                        daddr  <= {2'b00, channel};
                        ch_idx <= {channel[3], channel[0]};
                    end
                end
                S_REQ: wait_cnt <= '0;
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (drdy)              raw         <= do_in[15:4];
                    else if (wait_expired) timeout_err <= 1'b1;
                end
                S_STORE: begin
                    ch_val[ch_idx] <= filt_val;
                    primed[ch_idx] <= 1'b1;
                    sample_valid   <= 1'b1;
                    sample_ch      <= ch_idx;
                end
                default: ;
            endcase
        end
    end

    assign ch6_val  = ch_val[0];
    assign ch7_val  = ch_val[1];
    assign ch14_val = ch_val[2];
    assign ch15_val = ch_val[3];

endmodule

// File: tb/tb_xadc_channel_reader.sv
// Directed bench for xadc_channel_reader (FILT_SHIFT=2, TIMEOUT=8) with hand-computed expectations.
module tb_xadc_channel_reader;

    logic        CLK100MHZ = 1'b0;
    logic        rst_n = 1'b0;
    logic        eoc = 1'b0;
    logic [4:0]  channel = '0;
    logic        drdy = 1'b0;
    logic [15:0] do_in = '0;
    logic        den, dwe, sample_valid, timeout_err;
    logic [6:0]  daddr;
    logic [11:0] ch6_val, ch7_val, ch14_val, ch15_val;
    logic [1:0]  sample_ch, state_dbg;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int den_cnt, sv_cnt, sv_cyc, t0;
    logic [6:0] den_addr;
    logic [1:0] sv_ch;

    xadc_channel_reader #(.FILT_SHIFT(2), .TIMEOUT(8)) dut (
        .CLK100MHZ(CLK100MHZ), .rst_n(rst_n), .eoc(eoc), .channel(channel),
        .drdy(drdy), .do_in(do_in), .den(den), .daddr(daddr), .dwe(dwe),
        .ch6_val(ch6_val), .ch7_val(ch7_val), .ch14_val(ch14_val), .ch15_val(ch15_val),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .timeout_err(timeout_err),
        .state_dbg(state_dbg)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;
    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    always @(negedge CLK100MHZ) begin
        if (den) begin den_cnt++; den_addr = daddr; end
        if (sample_valid) begin sv_cnt++; sv_ch = sample_ch; sv_cyc = cyc; end
    end

    // eoc in cycle 0, den in cycle 1, drdy d cycles after den (d >= 1).
    task automatic run_read(input logic [4:0] ch, input logic [15:0] data, input int d, input bit busy_eoc);
        den_cnt = 0; sv_cnt = 0;
        @(posedge CLK100MHZ); #1; eoc = 1'b1; channel = ch; t0 = cyc;
        @(posedge CLK100MHZ); #1; eoc = 1'b0;
        for (int i = 0; i < d; i++) begin
            @(posedge CLK100MHZ); #1;
            eoc = busy_eoc && (i == 1); channel = 5'h16;
        end
        eoc = 1'b0; drdy = 1'b1; do_in = data;
        @(posedge CLK100MHZ); #1; drdy = 1'b0; do_in = '0;
        repeat (4) @(posedge CLK100MHZ); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge CLK100MHZ); #1;
        total++; if (den !== 1'b0) begin bad++; $display("FAIL reset_den got=%b want=0", den); end
        total++; if (daddr !== 7'h00) begin bad++; $display("FAIL reset_daddr got=%h want=00", daddr); end
        total++; if (dwe !== 1'b0) begin bad++; $display("FAIL reset_dwe got=%b want=0", dwe); end
        total++; if ({ch6_val, ch7_val, ch14_val, ch15_val} !== 48'h0) begin bad++; $display("FAIL reset_vals got=%h want=0", {ch6_val, ch7_val, ch14_val, ch15_val}); end
        total++; if ({sample_valid, sample_ch, timeout_err} !== 4'h0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {sample_valid, sample_ch, timeout_err}); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
        rst_n = 1'b1;
        @(posedge CLK100MHZ); #1;
    endtask

    task automatic test_basic;
        run_read(5'h1E, 16'hA5C0, 3, 1'b0);
        total++; if (den_cnt !== 1) begin bad++; $display("FAIL basic_den_count got=%0d want=1", den_cnt); end
        total++; if (den_addr !== 7'h1E) begin bad++; $display("FAIL basic_daddr got=%h want=1e", den_addr); end
        total++; if (ch14_val !== 12'hA5C) begin bad++; $display("FAIL basic_ch14 got=%h want=a5c", ch14_val); end
        total++; if (sv_cnt !== 1) begin bad++; $display("FAIL basic_sv_count got=%0d want=1", sv_cnt); end
        total++; if (sv_ch !== 2'd2) begin bad++; $display("FAIL basic_sample_ch got=%0d want=2", sv_ch); end
        total++; if (sv_cyc - t0 !== 6) begin bad++; $display("FAIL basic_latency got=%0d want=6", sv_cyc - t0); end
        total++; if ({ch6_val, ch7_val, ch15_val} !== 36'h0) begin bad++; $display("FAIL basic_others got=%h want=0", {ch6_val, ch7_val, ch15_val}); end
    endtask

    task automatic test_filter;
        run_read(5'h16, 16'h4000, 2, 1'b0);
        total++; if (ch6_val !== 12'h400) begin bad++; $display("FAIL filt_prime got=%h want=400", ch6_val); end
        run_read(5'h16, 16'h8000, 2, 1'b0);
        total++; if (ch6_val !== 12'h500) begin bad++; $display("FAIL filt_up got=%h want=500", ch6_val); end
        total++; if (sv_ch !== 2'd0) begin bad++; $display("FAIL filt_sample_ch got=%0d want=0", sv_ch); end
        run_read(5'h16, 16'h0000, 1, 1'b0);
        total++; if (ch6_val !== 12'h3C0) begin bad++; $display("FAIL filt_down got=%h want=3c0", ch6_val); end
        total++; if (ch14_val !== 12'hA5C) begin bad++; $display("FAIL filt_ch14_kept got=%h want=a5c", ch14_val); end
    endtask

    task automatic test_ignore;
        den_cnt = 0; sv_cnt = 0;
        @(posedge CLK100MHZ); #1; eoc = 1'b1; channel = 5'h03;
        @(posedge CLK100MHZ); #1; eoc = 1'b0;
        repeat (3) @(posedge CLK100MHZ); #1;
        total++; if (den_cnt !== 0) begin bad++; $display("FAIL nonaux_den got=%0d want=0", den_cnt); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL nonaux_state got=%0d want=0", state_dbg); end
        drdy = 1'b1; do_in = 16'hFFF0;
        @(posedge CLK100MHZ); #1; drdy = 1'b0; do_in = '0;
        repeat (3) @(posedge CLK100MHZ); #1;
        total++; if (sv_cnt !== 0) begin bad++; $display("FAIL idle_drdy_sv got=%0d want=0", sv_cnt); end
        total++; if (ch6_val !== 12'h3C0) begin bad++; $display("FAIL idle_drdy_ch6 got=%h want=3c0", ch6_val); end
        run_read(5'h17, 16'h1230, 5, 1'b1);
        total++; if (den_cnt !== 1) begin bad++; $display("FAIL busy_den got=%0d want=1", den_cnt); end
        total++; if (sv_cnt !== 1) begin bad++; $display("FAIL busy_sv got=%0d want=1", sv_cnt); end
        total++; if (ch7_val !== 12'h123) begin bad++; $display("FAIL busy_ch7 got=%h want=123", ch7_val); end
        total++; if (ch6_val !== 12'h3C0) begin bad++; $display("FAIL busy_ch6_kept got=%h want=3c0", ch6_val); end
    endtask

    task automatic test_back_to_back;
        den_cnt = 0; sv_cnt = 0;
        @(posedge CLK100MHZ); #1; eoc = 1'b1; channel = 5'h1F;
        @(posedge CLK100MHZ); #1; eoc = 1'b0;
        @(posedge CLK100MHZ); #1; drdy = 1'b1; do_in = 16'h8880;
        @(posedge CLK100MHZ); #1; drdy = 1'b0; do_in = '0;
        @(posedge CLK100MHZ); #1; eoc = 1'b1; channel = 5'h1E;
        total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL b2b_sv got=%b want=1", sample_valid); end
        total++; if (ch15_val !== 12'h888) begin bad++; $display("FAIL b2b_ch15 got=%h want=888", ch15_val); end
        @(posedge CLK100MHZ); #1; eoc = 1'b0;
        total++; if ({den, daddr} !== {1'b1, 7'h1E}) begin bad++; $display("FAIL b2b_den got=%b/%h want=1/1e", den, daddr); end
        @(posedge CLK100MHZ); #1; drdy = 1'b1; do_in = 16'h0000;
        @(posedge CLK100MHZ); #1; drdy = 1'b0;
        repeat (3) @(posedge CLK100MHZ); #1;
        total++; if (ch14_val !== 12'h7C5) begin bad++; $display("FAIL b2b_ch14 got=%h want=7c5", ch14_val); end
        total++; if ({den_cnt, sv_cnt} !== {32'd2, 32'd2}) begin bad++; $display("FAIL b2b_counts got=%0d/%0d want=2/2", den_cnt, sv_cnt); end
    endtask

    task automatic test_timeout;
        den_cnt = 0; sv_cnt = 0;
        @(posedge CLK100MHZ); #1; eoc = 1'b1; channel = 5'h17;
        @(posedge CLK100MHZ); #1; eoc = 1'b0;
        repeat (8) @(posedge CLK100MHZ); #1;
        total++; if ({state_dbg, timeout_err} !== {2'd2, 1'b0}) begin bad++; $display("FAIL to_last_wait got=%0d/%b want=2/0", state_dbg, timeout_err); end
        @(posedge CLK100MHZ); #1;
        total++; if ({state_dbg, timeout_err} !== {2'd0, 1'b1}) begin bad++; $display("FAIL to_expired got=%0d/%b want=0/1", state_dbg, timeout_err); end
        repeat (3) @(posedge CLK100MHZ); #1;
        total++; if (sv_cnt !== 0) begin bad++; $display("FAIL to_no_sv got=%0d want=0", sv_cnt); end
        total++; if (ch7_val !== 12'h123) begin bad++; $display("FAIL to_ch7_kept got=%h want=123", ch7_val); end
        run_read(5'h17, 16'h5230, 2, 1'b0);
        total++; if (ch7_val !== 12'h223) begin bad++; $display("FAIL to_recover_ch7 got=%h want=223", ch7_val); end
        total++; if ({sv_cnt, timeout_err} !== {32'd1, 1'b1}) begin bad++; $display("FAIL to_recover_flags got=%0d/%b want=1/1", sv_cnt, timeout_err); end
    endtask

    task automatic test_reset_mid_wait;
        den_cnt = 0; sv_cnt = 0;
        @(posedge CLK100MHZ); #1; eoc = 1'b1; channel = 5'h16;
        @(posedge CLK100MHZ); #1; eoc = 1'b0;
        @(posedge CLK100MHZ); #1;
        @(posedge CLK100MHZ); #1; rst_n = 1'b0;
        #1;
        total++; if ({state_dbg, den, daddr, dwe} !== 11'h0) begin bad++; $display("FAIL rst_mid_ctrl got=%h want=0", {state_dbg, den, daddr, dwe}); end
        total++; if ({ch6_val, ch7_val, ch14_val, ch15_val} !== 48'h0) begin bad++; $display("FAIL rst_mid_vals got=%h want=0", {ch6_val, ch7_val, ch14_val, ch15_val}); end
        total++; if ({sample_valid, sample_ch, timeout_err} !== 4'h0) begin bad++; $display("FAIL rst_mid_flags got=%b want=0000", {sample_valid, sample_ch, timeout_err}); end
        @(posedge CLK100MHZ); #1; rst_n = 1'b1;
        @(posedge CLK100MHZ); #1; drdy = 1'b1; do_in = 16'h7770;
        @(posedge CLK100MHZ); #1; drdy = 1'b0; do_in = '0;
        repeat (3) @(posedge CLK100MHZ); #1;
        total++; if ({sv_cnt, ch6_val} !== {32'd0, 12'h000}) begin bad++; $display("FAIL late_drdy got=%0d/%h want=0/000", sv_cnt, ch6_val); end
        run_read(5'h17, 16'hFFF0, 2, 1'b0);
        total++; if (ch7_val !== 12'hFFF) begin bad++; $display("FAIL unprimed_ch7 got=%h want=fff", ch7_val); end
        total++; if ({sv_cnt, sv_ch} !== {32'd1, 2'd1}) begin bad++; $display("FAIL unprimed_sv got=%0d/%0d want=1/1", sv_cnt, sv_ch); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_filter;
        test_ignore;
        test_back_to_back;
        test_timeout;
        test_reset_mid_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
